// File: rtl/shift_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_mult_ctrl
//   Sequential shift-and-add multiplier for the multicycle MULT path.
//   Starting at the LSB, the controller takes one multiplier bit per RUN
//   cycle. When that bit is 1 it adds the running multiplicand into a
//   2*WIDTH accumulator. The multiplicand then moves one bit left.
//   The ALU stage stalls while busy is high.
//
// Parameters
//   WIDTH       operand width; product is 2*WIDTH bits
//   EARLY_EXIT  1 = finish once the remaining multiplier bits are all zero
//
// Ports
//   clock         in   1        system clock, rising edge
//   reset_n       in   1        asynchronous active-low reset
//   start         in   1        request, accepted only while ready=1
//   multiplicand  in   WIDTH    operand A (unsigned), sampled on accept
//   multiplier    in   WIDTH    operand B (unsigned), sampled on accept
//   ready         out  1        high in IDLE only
//   busy          out  1        high in RUN and DONE
//   done          out  1        one-cycle pulse, product/overflow valid
//   product       out  2*WIDTH  A*B, held until the next accepted start
//   overflow      out  1        upper half of product is non-zero
// -----------------------------------------------------------------------------
module shift_mult_ctrl #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mc_q, mc_d;
  logic [WIDTH-1:0]  mp_q, mp_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              overflow_q, overflow_d;

  // Accumulator value after the current step's conditional add.
  logic [PW-1:0]     acc_step;
  logic              last_step;

  always_comb begin
    acc_step = mp_q[0] ? (acc_q + mc_q) : acc_q;
    // Either all WIDTH bits are consumed, or (early exit) no set bits remain
    // above the one being processed now.
    last_step = (cnt_q == CNT_LAST) ||
                (EARLY_EXIT && ((mp_q >> 1) == '0));
  end

  always_comb begin
    state_d    = state_q;
    mc_d       = mc_q;
    mp_d       = mp_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = {{WIDTH{1'b0}}, multiplicand};
          mp_d    = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        mc_d  = {mc_q[PW-2:0], 1'b0};
        mp_d  = mp_q >> 1;
        if (last_step) begin
          // Counter holds on the final step so it never wraps mid-operation.
          // Product/overflow are only written here, so they stay stable in RUN.
          product_d  = acc_step;
          overflow_d = |acc_step[PW-1:WIDTH];
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mc_q       <= '0;
      mp_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mc_q       <= mc_d;
      mp_q       <= mp_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_mult_ctrl
//   Directed bench for shift_mult_ctrl. One instance uses the full-length
//   sequence and a second uses early exit. Expected values are worked out
//   by hand.
// -----------------------------------------------------------------------------
module tb_shift_mult_ctrl;

  logic        clock;
  logic        reset_n;

  logic        start0, ready0, busy0, done0, overflow0;
  logic [31:0] a0, b0;
  logic [63:0] product0;

  logic        start1, ready1, busy1, done1, overflow1;
  logic [31:0] a1, b1;
  logic [63:0] product1;

  int checks;
  int errors;
  int done_cnt0;

  shift_mult_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start0),
    .multiplicand (a0),
    .multiplier   (b0),
    .ready        (ready0),
    .busy         (busy0),
    .done         (done0),
    .product      (product0),
    .overflow     (overflow0)
  );

  shift_mult_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_ee (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start1),
    .multiplicand (a1),
    .multiplier   (b1),
    .ready        (ready1),
    .busy         (busy1),
    .done         (done1),
    .product      (product1),
    .overflow     (overflow1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count done pulses seen by the main instance.
  initial done_cnt0 = 0;
  always @(posedge clock) if (done0 === 1'b1) done_cnt0++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept at E0, then wait for done. Checks the edge count, the product
  // stability during RUN, the result and the return to ready.
  task automatic run0(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] ep, input logic eo, input string tag);
    int          n;
    logic [63:0] prev;
    bit          glitch;
    prev   = product0;
    glitch = 0;
    a0 = a; b0 = b; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy0}, 64'd1);
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
      if (!done0 && product0 !== prev) glitch = 1;
    end
    chk({tag, "_edges"},    64'(n), 64'd32);
    chk({tag, "_noglitch"}, {63'd0, glitch}, 64'd0);
    chk({tag, "_product"},  product0, ep);
    chk({tag, "_overflow"}, {63'd0, overflow0}, {63'd0, eo});
    tick();
    chk({tag, "_ready"},    {63'd0, ready0}, 64'd1);
    chk({tag, "_donelow"},  {63'd0, done0}, 64'd0);
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] ep, input int edges, input string tag);
    int n;
    a1 = a; b1 = b; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_edges"},   64'(n), 64'(edges));
    chk({tag, "_product"}, product1, ep);
    tick();
    chk({tag, "_ready"},   {63'd0, ready1}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pulses;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    #3;
    chk("rst_ready",    {63'd0, ready0},    64'd1);
    chk("rst_busy",     {63'd0, busy0},     64'd0);
    chk("rst_done",     {63'd0, done0},     64'd0);
    chk("rst_product",  product0,           64'd0);
    chk("rst_overflow", {63'd0, overflow0}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: 3*5, exact latency
    run0(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, "t1");

    // 2: max operands
    run0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "t2");

    // 3: overflow into the upper half, and a zero multiplier
    run0(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1, "t3a");
    run0(32'h0000_1234, 32'd0, 64'd0, 1'b0, "t3b");

    // 4: a start pulse during RUN is ignored
    pulses = done_cnt0;
    a0 = 32'd7; b0 = 32'd9; start0 = 1'b1;
    tick();                       // E0
    start0 = 1'b0;
    repeat (4) tick();            // E1..E4
    a0 = 32'd1; b0 = 32'd1; start0 = 1'b1;
    tick();                       // E5
    start0 = 1'b0;
    n = 5;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_edges",   64'(n), 64'd32);
    chk("t4_product", product0, 64'd63);
    tick();
    tick();
    chk("t4_pulses",  64'(done_cnt0 - pulses), 64'd1);
    chk("t4_ready",   {63'd0, ready0}, 64'd1);

    // Start held high: back-to-back ops with a single IDLE cycle between them
    a0 = 32'd3; b0 = 32'd4; start0 = 1'b1;
    tick();                       // E0
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk("hold_edges",   64'(n), 64'd32);
    chk("hold_product", product0, 64'd12);
    tick();                       // E33 -> IDLE
    chk("hold_idle",    {63'd0, ready0}, 64'd1);
    a0 = 32'd6; b0 = 32'd7;
    tick();                       // E34 accepts again
    chk("hold_reaccept", {63'd0, busy0}, 64'd1);
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk("hold2_edges",   64'(n), 64'd32);
    chk("hold2_product", product0, 64'd42);
    tick();

    // 5: asynchronous reset mid-RUN aborts without a done pulse
    pulses = done_cnt0;
    a0 = 32'd5; b0 = 32'd7; start0 = 1'b1;
    tick();                       // E0
    start0 = 1'b0;
    repeat (9) tick();            // E1..E9
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_ready",    {63'd0, ready0},    64'd1);
    chk("t5_busy",     {63'd0, busy0},     64'd0);
    chk("t5_done",     {63'd0, done0},     64'd0);
    chk("t5_product",  product0,           64'd0);
    chk("t5_overflow", {63'd0, overflow0}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (40) tick();
    chk("t5_nopulse",  64'(done_cnt0 - pulses), 64'd0);
    run0(32'd2, 32'd3, 64'd6, 1'b0, "t5b");

    // 6: early exit
    run1(32'h10, 32'd5, 64'h50, 3, "t6a");
    run1(32'h10, 32'd0, 64'd0, 1, "t6b");
    run1(32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000, 32, "t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
